// File: rtl/cond_logic.sv
//==============================================================================
// Module      : cond_logic
// Description : ARM condition unit. Holds the NZCV flag register, evaluates the
//               Cond field against the stored flags and gates the PC, register
//               file and memory write enables. The optional skip counter is
//               built when COND_STATS_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cond_logic #(
    parameter logic [3:0] FLAG_RST = 4'b0000
`ifdef COND_STATS_EN
    ,
    parameter int unsigned STAT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        CondEx,
    output logic [3:0]  Flags
`ifdef COND_STATS_EN
    ,
    input  logic              StatClr,
    output logic [STAT_W-1:0] SkipCount
`endif
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // N,Z and C,V halves load independently, and only for executed instructions
    always_comb begin
        flags_d = flags_q;
        if (cond_ex) begin
            if (FlagW[1]) begin
                flags_d[3:2] = ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                flags_d[1:0] = ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= FLAG_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS  & cond_ex;
    assign RegWrite = RegW & cond_ex;
    assign MemWrite = MemW & cond_ex;
    assign Flags    = flags_q;

`ifdef COND_STATS_EN
    logic [STAT_W-1:0] skip_q;
    logic [STAT_W-1:0] skip_d;

    // Clear wins over a same-cycle increment; the count sticks at all-ones
    always_comb begin
        skip_d = skip_q;
        if (StatClr) begin
            skip_d = '0;
        end else if (!cond_ex && (skip_q != {STAT_W{1'b1}})) begin
            skip_d = skip_q + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= '0;
        end else begin
            skip_q <= skip_d;
        end
    end

    assign SkipCount = skip_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cond_logic.sv
//==============================================================================
// Module      : tb_cond_logic
// Description : Scoreboard bench for cond_logic (COND_STATS_EN aware).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cond_logic;

    localparam logic [3:0] FLAG_RST = 4'b0000;
`ifdef COND_STATS_EN
    localparam int STAT_W = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
    logic       stat_clr;
`ifdef COND_STATS_EN
    logic [STAT_W-1:0] skip_count;
`endif

    cond_logic #(
        .FLAG_RST (FLAG_RST)
`ifdef COND_STATS_EN
        ,
        .STAT_W   (STAT_W)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
`ifdef COND_STATS_EN
        ,
        .StatClr  (stat_clr),
        .SkipCount(skip_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic       condex;
        logic [3:0] flags;
        int         skip;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_flags;
    int         m_skip;

    // Condition table: even codes test a predicate, odd codes its inverse
    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One instruction per cycle: retire the previous one into the model at the
    // edge, then present the next one between edges and queue its expectation.
    task automatic step(input logic rst, input logic [3:0] c, input logic [3:0] af,
                        input logic [1:0] fw, input logic pcs, input logic rw,
                        input logic mw, input logic clr);
        logic pass;
        exp_t e;
        @(posedge clk);
        if (!reset) begin
            pass = ref_pass(Cond, m_flags);
            if (stat_clr) m_skip = 0;
            else if (!pass && m_skip < 65535) m_skip = m_skip + 1;
            if (pass && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
            if (pass && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
        end
        #1;
        reset    = rst;
        Cond     = c;
        ALUFlags = af;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = rw;
        MemW     = mw;
        stat_clr = clr;
        if (rst) begin
            m_flags = FLAG_RST;
            m_skip  = 0;
        end
        pass       = ref_pass(c, m_flags);
        e.condex   = pass;
        e.pcsrc    = pcs && pass;
        e.regwrite = rw && pass;
        e.memwrite = mw && pass;
        e.flags    = m_flags;
        e.skip     = m_skip;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("CondEx",   {31'd0, CondEx},   {31'd0, e.condex});
                chk("PCSrc",    {31'd0, PCSrc},    {31'd0, e.pcsrc});
                chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.regwrite});
                chk("MemWrite", {31'd0, MemWrite}, {31'd0, e.memwrite});
                chk("Flags",    {28'd0, Flags},    {28'd0, e.flags});
`ifdef COND_STATS_EN
                begin
                    int sat;
                    sat = (e.skip > (1 << STAT_W) - 1) ? (1 << STAT_W) - 1 : e.skip;
                    chk("SkipCount", 32'(skip_count), 32'(sat));
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b1; Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b1; MemW = 1'b0; stat_clr = 1'b0;
        m_flags = FLAG_RST; m_skip = 0;

        // Reset state with AL and RegW
        step(1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0);
        // Load Z, then EQ passes and NE fails
        step(0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
        step(0, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0);
        step(0, 4'h1, 4'h0, 2'b00, 1, 1, 1, 0);
        // Failed NE with a flag write pending: nothing changes
        step(0, 4'h1, 4'b1011, 2'b11, 1, 0, 1, 0);
        step(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        // C,V half only, then GE fails and HI passes
        step(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        step(0, 4'hE, 4'b1111, 2'b01, 0, 0, 0, 0);
        step(0, 4'hA, 4'h0, 2'b00, 0, 1, 0, 0);
        step(0, 4'h8, 4'h0, 2'b00, 0, 1, 0, 0);
        // Flags=1001, then asynchronous reset between edges, then reserved code
        step(0, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0);
        step(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        step(1, 4'hF, 4'b0110, 2'b11, 1, 1, 1, 0);
        step(0, 4'hF, 4'h0, 2'b00, 1, 1, 1, 0);
        step(0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0);
        step(0, 4'hF, 4'h0, 2'b00, 1, 1, 1, 0);
        // Skip counter: saturate, then clear beats a same-cycle fail
        step(1, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0);
        step(0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 1);
        step(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
